soc_mem: RTL and testbench

SOC_MEM -- requirements
Module: soc_mem

---
 rtl/soc_mem_if.sv | 26 ++
 rtl/soc_mem.sv | 130 +++++++++++++
 tb/tb_soc_mem.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/soc_mem_if.sv
// Core-side bus of soc_mem: one access per cycle, plus console FIFO and halt sideband.
interface soc_mem_if #(
    parameter int M_WIDTH = 32
);
    localparam int A = M_WIDTH - $clog2(M_WIDTH / 8);

    logic [A-1:0]         addr;
    logic [M_WIDTH-1:0]   wdata;
    logic [M_WIDTH/8-1:0] wes;
    logic [M_WIDTH-1:0]   rdata;
    logic                 con_pop;
    logic [7:0]           con_data;
    logic                 con_valid;
    logic                 halt;
    logic [7:0]           halt_code;

    modport master (
        output addr, wdata, wes, con_pop,
        input  rdata, con_data, con_valid, halt, halt_code
    );

    modport slave (
        input  addr, wdata, wes, con_pop,
        output rdata, con_data, con_valid, halt, halt_code
    );
endinterface

// File: rtl/soc_mem.sv
// Simple SoC memory: byte-lane RAM at word 0, MMIO block (console FIFO,
// status, cycle counter, halt) at the top half of the word address space.
module soc_mem #(
    parameter int M_WIDTH     = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int CON_DEPTH   = 8
) (
    input  logic         clk,
    input  logic         rst,
    soc_mem_if.slave     bus
);
    localparam int NB  = M_WIDTH / 8;
    localparam int A   = M_WIDTH - $clog2(NB);
    localparam int RAW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW  = (CON_DEPTH > 1) ? $clog2(CON_DEPTH) : 1;
    localparam int CW  = PW + 1;

    localparam logic [A-1:0] MB     = {1'b1, {(A-1){1'b0}}};
    localparam logic [A-1:0] A_CON  = MB;
    localparam logic [A-1:0] A_STAT = MB + A'(1);
    localparam logic [A-1:0] A_CYC  = MB + A'(2);
    localparam logic [A-1:0] A_HALT = MB + A'(3);

    // RAM array is deliberately not reset so it can map onto block RAM.
    logic [M_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [M_WIDTH-1:0] ram_rd_q;
    logic [M_WIDTH-1:0] mmio_rd_q, mmio_rd_d;
    logic               sel_ram_q;

    logic [7:0]    buf_q [CON_DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [M_WIDTH-1:0] cyc_q;
    logic               halt_q, halt_d;
    logic [7:0]         hcode_q, hcode_d;

    logic           in_ram, any_we;
    logic [RAW-1:0] ram_idx;
    logic           full, empty, wr_con, pop_ok, push_ok, ovf_clr;
    logic [M_WIDTH-1:0] status;

    assign in_ram  = {1'b0, bus.addr} < (A+1)'(DEPTH_WORDS);
    assign ram_idx = bus.addr[RAW-1:0];
    assign any_we  = |bus.wes;

    // Console FIFO control, status word, halt latch and MMIO read mux.
    always_comb begin
        full    = (cnt_q == CW'(CON_DEPTH));
        empty   = (cnt_q == '0);
        wr_con  = !rst && (bus.addr == A_CON) && bus.wes[0];
        pop_ok  = !rst && bus.con_pop && !empty;
        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        push_ok = wr_con && (!full || pop_ok);
        ovf_clr = (bus.addr == A_STAT) && bus.wes[0] && bus.wdata[1];

        wp_d  = push_ok ? wp_q + PW'(1) : wp_q;
        rp_d  = pop_ok  ? rp_q + PW'(1) : rp_q;
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) cnt_d = cnt_q + CW'(1);
        if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);

        ovf_d = ovf_q;
        if (wr_con && full && !pop_ok) ovf_d = 1'b1;
        if (ovf_clr)                   ovf_d = 1'b0;

        halt_d  = halt_q;
        hcode_d = hcode_q;
        if (any_we && (bus.addr == A_HALT) && !halt_q) begin
            halt_d  = 1'b1;
            hcode_d = bus.wdata[7:0];
        end

        status       = '0;
        status[0]    = full;
        status[1]    = ovf_q;
        status[15:8] = 8'(cnt_q);

        mmio_rd_d = '0;
        if (bus.addr == A_STAT) mmio_rd_d = status;
        if (bus.addr == A_CYC)  mmio_rd_d = cyc_q;
    end

    // RAM byte-lane writes; the read register captures pre-write data.
    always_ff @(posedge clk) begin
        ram_rd_q <= mem_q[ram_idx];
        if (!rst && in_ram) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wes[i]) mem_q[ram_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // FIFO storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) buf_q[wp_q] <= bus.wdata[7:0];
    end

    // Resettable state: read source select, MMIO read data, FIFO pointers, counter, halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_ram_q <= 1'b0;
            mmio_rd_q <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            cyc_q     <= '0;
            halt_q    <= 1'b0;
            hcode_q   <= '0;
        end else begin
            sel_ram_q <= in_ram;
            mmio_rd_q <= mmio_rd_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            cyc_q     <= cyc_q + M_WIDTH'(1);
            halt_q    <= halt_d;
            hcode_q   <= hcode_d;
        end
    end

    assign bus.rdata     = sel_ram_q ? ram_rd_q : mmio_rd_q;
    assign bus.con_valid = !empty;
    assign bus.con_data  = empty ? 8'h00 : buf_q[rp_q];
    assign bus.halt      = halt_q;
    assign bus.halt_code = hcode_q;
endmodule

// File: tb/tb_soc_mem.sv
// Directed table-driven bench for soc_mem (M_WIDTH=32, DEPTH_WORDS=1024, CON_DEPTH=8).
module tb_soc_mem;
    localparam logic [29:0] MB = 30'h2000_0000;
    localparam logic [29:0] CN = MB;
    localparam logic [29:0] ST = MB + 30'd1;
    localparam logic [29:0] CY = MB + 30'd2;
    localparam logic [29:0] HT = MB + 30'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    soc_mem_if #(.M_WIDTH(32)) bus();
    soc_mem #(.M_WIDTH(32), .DEPTH_WORDS(1024), .CON_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        string       name;
        logic        r;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wes;
        logic        pop;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bit          chk_con;
        logic        exp_cv;
        logic [7:0]  exp_cd;
        bit          chk_h;
        logic        exp_h;
        logic [7:0]  exp_hc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic r, logic [29:0] a, logic [31:0] d,
                                logic [3:0] w, logic p);
        vec_t v;
        v.name = n; v.r = r; v.addr = a; v.wdata = d; v.wes = w; v.pop = p;
        v.chk_rd = 0; v.exp_rd = '0;
        v.chk_con = 0; v.exp_cv = 0; v.exp_cd = '0;
        v.chk_h = 0; v.exp_h = 0; v.exp_hc = '0;
        return v;
    endfunction
    function automatic vec_t rd(vec_t v, logic [31:0] e);
        v.chk_rd = 1; v.exp_rd = e; return v;
    endfunction
    function automatic vec_t cn(vec_t v, logic cv, logic [7:0] cd);
        v.chk_con = 1; v.exp_cv = cv; v.exp_cd = cd; return v;
    endfunction
    function automatic vec_t hl(vec_t v, logic h, logic [7:0] hc);
        v.chk_h = 1; v.exp_h = h; v.exp_hc = hc; return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    // Drive one cycle, then check outputs just after the capturing edge.
    task automatic apply(input vec_t v);
        rst = v.r; bus.addr = v.addr; bus.wdata = v.wdata; bus.wes = v.wes; bus.con_pop = v.pop;
        @(posedge clk);
        #1;
        if (v.chk_rd) chk({v.name, ".rdata"}, bus.rdata, v.exp_rd);
        if (v.chk_con) begin
            chk({v.name, ".con_valid"}, {31'b0, bus.con_valid}, {31'b0, v.exp_cv});
            chk({v.name, ".con_data"},  {24'b0, bus.con_data},  {24'b0, v.exp_cd});
        end
        if (v.chk_h) begin
            chk({v.name, ".halt"},      {31'b0, bus.halt},      {31'b0, v.exp_h});
            chk({v.name, ".halt_code"}, {24'b0, bus.halt_code}, {24'b0, v.exp_hc});
        end
    endtask

    logic [31:0] r1, r2;
    logic [7:0]  heads [8];

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.wes = '0; bus.con_pop = 1'b0;

        // Reset state
        tbl.push_back(mk("rst0", 1, 0, 0, 0, 0));
        tbl.push_back(hl(cn(rd(mk("rst1", 1, 0, 0, 0, 0), 0), 0, 8'h00), 0, 8'h00));
        // RAM byte lanes and read-during-write
        tbl.push_back(mk("w5", 0, 5, 32'hDEADBEEF, 4'hF, 0));
        tbl.push_back(rd(mk("w5lane1", 0, 5, 32'h0000AA00, 4'h2, 0), 32'hDEADBEEF));
        tbl.push_back(rd(mk("r5", 0, 5, 0, 0, 0), 32'hDEADAAEF));
        tbl.push_back(mk("w7", 0, 7, 32'h5, 4'hF, 0));
        tbl.push_back(rd(mk("rw7", 0, 7, 32'h1, 4'hF, 0), 32'h5));
        tbl.push_back(rd(mk("r7", 0, 7, 0, 0, 0), 32'h1));
        tbl.push_back(rd(mk("w5lane3", 0, 5, 32'h11000000, 4'h8, 0), 32'hDEADAAEF));
        tbl.push_back(rd(mk("r5b", 0, 5, 0, 0, 0), 32'h11ADAAEF));
        // Unmapped: read 0, write ignored (no aliasing onto word 0)
        tbl.push_back(mk("w0", 0, 0, 32'h0000CAFE, 4'hF, 0));
        tbl.push_back(rd(mk("wunm", 0, 30'd1024, 32'h1234, 4'hF, 0), 0));
        tbl.push_back(rd(mk("r0", 0, 0, 0, 0, 0), 32'h0000CAFE));
        tbl.push_back(rd(mk("runm", 0, MB + 30'd4, 0, 0, 0), 0));
        tbl.push_back(rd(mk("rtx", 0, CN, 0, 0, 0), 0));
        tbl.push_back(rd(mk("rhalt", 0, HT, 0, 0, 0), 0));
        // Console FIFO
        tbl.push_back(mk("pushlane1", 0, CN, 32'h99, 4'h2, 0));
        tbl.push_back(cn(rd(mk("st0", 0, ST, 0, 0, 0), 0), 0, 8'h00));
        for (int i = 0; i < 9; i++)
            tbl.push_back(cn(mk("push", 0, CN, 32'h41 + i, 4'h1, 0), 1, 8'h41));
        tbl.push_back(rd(mk("st_full", 0, ST, 0, 0, 0), 32'h0803));
        for (int i = 0; i < 8; i++)
            tbl.push_back(cn(mk($sformatf("pop%0d", i), 0, 0, 0, 0, 1),
                             i < 7, (i < 7) ? 8'(8'h42 + i) : 8'h00));
        tbl.push_back(cn(mk("pop_empty", 0, 0, 0, 0, 1), 0, 8'h00));
        tbl.push_back(rd(mk("st_empty", 0, ST, 0, 0, 0), 32'h0002));
        tbl.push_back(cn(mk("pushpop_empty", 0, CN, 32'h77, 4'h1, 1), 1, 8'h77));
        tbl.push_back(rd(mk("st_one", 0, ST, 0, 0, 0), 32'h0102));
        tbl.push_back(cn(mk("pop77", 0, 0, 0, 0, 1), 0, 8'h00));
        tbl.push_back(rd(mk("clr_lane1", 0, ST, 32'h2, 4'h2, 0), 32'h0002));
        tbl.push_back(rd(mk("st_noclr", 0, ST, 0, 0, 0), 32'h0002));
        tbl.push_back(rd(mk("clr", 0, ST, 32'h2, 4'h1, 0), 32'h0002));
        tbl.push_back(rd(mk("st_clr", 0, ST, 0, 0, 0), 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk("fill", 0, CN, 32'h61 + i, 4'h1, 0));
        tbl.push_back(rd(mk("st_f8", 0, ST, 0, 0, 0), 32'h0801));
        tbl.push_back(cn(mk("pushpop_full", 0, CN, 32'h50, 4'h1, 1), 1, 8'h62));
        tbl.push_back(rd(mk("st_pp", 0, ST, 0, 0, 0), 32'h0801));
        tbl.push_back(cn(mk("push_ovf", 0, CN, 32'h51, 4'h1, 0), 1, 8'h62));
        tbl.push_back(rd(mk("st_ovf", 0, ST, 0, 0, 0), 32'h0803));
        heads = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h50, 8'h00};
        for (int i = 0; i < 8; i++)
            tbl.push_back(cn(mk($sformatf("drain%0d", i), 0, 0, 0, 0, 1), i < 7, heads[i]));
        tbl.push_back(mk("clr2", 0, ST, 32'h2, 4'h1, 0));
        // Halt: first write wins
        tbl.push_back(hl(mk("halt7", 0, HT, 32'h07, 4'h1, 0), 1, 8'h07));
        tbl.push_back(hl(rd(mk("halt9", 0, HT, 32'h09, 4'hF, 0), 0), 1, 8'h07));
        // Mid-operation reset with in-flight read, write and push
        tbl.push_back(cn(mk("push_ab", 0, CN, 32'hAB, 4'h1, 0), 1, 8'hAB));
        tbl.push_back(mk("rd5_pre", 0, 5, 0, 0, 0));
        tbl.push_back(rd(mk("rst_w5", 1, 5, 32'hFFFFFFFF, 4'hF, 0), 0));
        tbl.push_back(hl(cn(rd(mk("rst_push", 1, CN, 32'hCC, 4'h1, 0), 0), 0, 8'h00), 0, 8'h00));
        tbl.push_back(rd(mk("cyc0", 0, CY, 0, 0, 0), 0));
        tbl.push_back(rd(mk("cyc1", 0, CY, 0, 0, 0), 1));
        tbl.push_back(cn(rd(mk("r5post", 0, 5, 0, 0, 0), 32'h11ADAAEF), 0, 8'h00));
        tbl.push_back(rd(mk("st_post", 0, ST, 0, 0, 0), 0));
        tbl.push_back(hl(mk("halt_again", 0, HT, 32'h09, 4'h1, 0), 1, 8'h09));

        foreach (tbl[i]) apply(tbl[i]);

        // CYCLE: two reads three cycles apart, a write in between is ignored
        apply(mk("cycA", 0, CY, 0, 0, 0));
        r1 = bus.rdata;
        apply(mk("idle", 0, 0, 0, 0, 0));
        apply(mk("cycW", 0, CY, 32'h0, 4'hF, 0));
        apply(mk("cycB", 0, CY, 0, 0, 0));
        r2 = bus.rdata;
        chk("cycle_diff", r2 - r1, 32'd3);

        // rdata holds while addr holds
        apply(mk("w9", 0, 9, 32'h13572468, 4'hF, 0));
        apply(rd(mk("r9a", 0, 9, 0, 0, 0), 32'h13572468));
        apply(rd(mk("r9b", 0, 9, 0, 0, 0), 32'h13572468));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
